// File: rtl/sum_n_ctrl.sv
// Sequencer for the shared FA adder: accumulates N operands through the external
// adder and reports the final sum, a sticky overflow flag and a done pulse.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last run
// ACC   | accepting operands, one add per transfer
// DONE  | one-cycle result-valid pulse
module sum_n_ctrl #(
    parameter int DW = 4,
    parameter int SW = 7,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          din_ready,
    output logic [DW-1:0] fa_x,
    output logic [SW-1:0] fa_y,
    output logic          fa_cin,
    input  logic [SW-1:0] fa_s,
    input  logic          fa_cout,
    output logic [SW-1:0] sum,
    output logic          ovf,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] acc, acc_nx;
    logic [SW-1:0] sum_r, sum_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          ovf_r, ovf_nx;

    // FA is combinational, so the add result is consumed in the same cycle
    assign fa_x   = din;
    assign fa_y   = acc;
    assign fa_cin = 1'b0;
    assign sum    = sum_r;
    assign ovf    = ovf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sum_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            sum_r <= sum_nx;
            ovf_r <= ovf_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        sum_nx    = sum_r;
        ovf_nx    = ovf_r;
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    ovf_nx = 1'b0;
                    if (n == '0) begin
                        sum_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        acc_nx   = '0;
                        cnt_nx   = n;
                        state_nx = ACC;
                    end
                end
            end
            ACC: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid) begin
                    acc_nx = fa_s;
                    ovf_nx = ovf_r | fa_cout;
                    cnt_nx = cnt - 1'b1;
                    if (cnt == {{(CW-1){1'b0}}, 1'b1}) begin
                        sum_nx   = fa_s;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sum_n_ctrl.sv
// Bench for sum_n_ctrl: vector table of runs, scoreboard of expected results
// popped on each done pulse, plus a hand-written mid-run reset sequence.
module tb_sum_n_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n_in;
    logic       din_valid;
    logic [3:0] din;
    logic       din_ready;
    logic [3:0] fa_x;
    logic [6:0] fa_y;
    logic       fa_cin;
    logic [6:0] fa_s;
    logic       fa_cout;
    logic [6:0] sum;
    logic       ovf;
    logic       busy;
    logic       done;
    logic [7:0] fa_full;

    sum_n_ctrl #(.DW(4), .SW(7), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n(n_in),
        .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin),
        .fa_s(fa_s), .fa_cout(fa_cout),
        .sum(sum), .ovf(ovf), .busy(busy), .done(done)
    );

    // the FA instance the controller drives
    assign fa_full = {4'b0, fa_x} + {1'b0, fa_y} + {7'b0, fa_cin};
    assign fa_s    = fa_full[6:0];
    assign fa_cout = fa_full[7];

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic [15:0][3:0] ops;
        logic [15:0][1:0] gaps;
        logic [6:0]       exp_sum;
        logic             exp_ovf;
        bit               hold;
    } vec_t;

    vec_t       vt[8];
    logic [7:0] sb[$];
    int total = 0;
    int bad   = 0;
    int done_cnt, busy_cnt, rdy_cnt;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (din_ready) rdy_cnt++;
            if (done) begin
                logic [7:0] e;
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_sum", int'(sum), int'(e[6:0]));
                    chk("sb_ovf", int'(ovf), int'(e[7]));
                end
            end
        end
    end

    task automatic run_vec(input int i);
        logic [6:0] racc;
        int gsum;
        int t;
        @(posedge clk); #1;
        busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
        n_in  = 4'(vt[i].n);
        start = 1'b1;
        sb.push_back({vt[i].exp_ovf, vt[i].exp_sum});
        @(posedge clk); #1;
        start = vt[i].hold;
        racc = '0;
        gsum = 0;
        for (int k = 0; k < vt[i].n; k++) begin
            for (int g = 0; g < int'(vt[i].gaps[k]); g++) begin
                din_valid = 1'b0;
                din = 4'hF;
                @(negedge clk);
                chk("gap_acc_hold", int'(fa_y), int'(racc));
                @(posedge clk); #1;
                gsum++;
            end
            din_valid = 1'b1;
            din = vt[i].ops[k];
            t = 0;
            while (!din_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 20) chk("ready_timeout", 0, 1);
            @(posedge clk); #1;
            racc = racc + 7'(vt[i].ops[k]);
        end
        din_valid = 1'b0;
        chk("done_after_last", int'(done), 1);
        chk("ready_low_in_done", int'(din_ready), 0);
        chk("sum_at_done", int'(sum), int'(vt[i].exp_sum));
        @(posedge clk); #1;
        chk("idle_busy_low", int'(busy), 0);
        chk("idle_done_low", int'(done), 0);
        start = 1'b0;
        chk("done_count", done_cnt, 1);
        chk("busy_cycles", busy_cnt, vt[i].n + gsum + 1);
        chk("ready_cycles", rdy_cnt, vt[i].n + gsum);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vt[i].ops  = '0;
            vt[i].gaps = '0;
            vt[i].hold = 1'b0;
        end
        vt[0].n = 3;  vt[0].ops[0] = 4'd5; vt[0].ops[1] = 4'd7; vt[0].ops[2] = 4'd9;
        vt[0].exp_sum = 7'd21; vt[0].exp_ovf = 1'b0;
        vt[1].n = 8;  for (int k = 0; k < 8; k++) vt[1].ops[k] = 4'd15;
        vt[1].exp_sum = 7'd120; vt[1].exp_ovf = 1'b0;
        vt[2].n = 10; for (int k = 0; k < 10; k++) vt[2].ops[k] = 4'd15;
        vt[2].exp_sum = 7'd22; vt[2].exp_ovf = 1'b1;
        vt[3].n = 1;  vt[3].ops[0] = 4'd3;
        vt[3].exp_sum = 7'd3; vt[3].exp_ovf = 1'b0;
        vt[4].n = 0;
        vt[4].exp_sum = 7'd0; vt[4].exp_ovf = 1'b0;
        vt[5].n = 4;  vt[5].hold = 1'b1;
        vt[5].ops[0] = 4'd1; vt[5].ops[1] = 4'd2; vt[5].ops[2] = 4'd3; vt[5].ops[3] = 4'd4;
        vt[5].gaps[0] = 2'd0; vt[5].gaps[1] = 2'd2; vt[5].gaps[2] = 2'd1; vt[5].gaps[3] = 2'd3;
        vt[5].exp_sum = 7'd10; vt[5].exp_ovf = 1'b0;
        vt[6].n = 15; for (int k = 0; k < 15; k++) vt[6].ops[k] = 4'd15;
        vt[6].exp_sum = 7'd97; vt[6].exp_ovf = 1'b1;
        vt[7].n = 2;  vt[7].ops[0] = 4'd6; vt[7].ops[1] = 4'd6;
        vt[7].exp_sum = 7'd12; vt[7].exp_ovf = 1'b0;

        rst_n = 1'b0; start = 1'b0; n_in = '0; din_valid = 1'b0; din = '0;
        busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(din_ready), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_acc", int'(fa_y), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // ovf is already set from the n=15 run; reset partway into a new run
        @(posedge clk); #1;
        done_cnt = 0;
        n_in = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mid_ovf_cleared_by_start", int'(ovf), 0);
        din_valid = 1'b1; din = 4'd3;
        @(posedge clk); #1;
        din = 4'd4;
        @(posedge clk); #1;
        din_valid = 1'b0;
        chk("mid_acc_before_rst", int'(fa_y), 7);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_sum", int'(sum), 0);
        chk("mrst_ovf", int'(ovf), 0);
        chk("mrst_ready", int'(din_ready), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_acc", int'(fa_y), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("mrst_no_done", done_cnt, 0);
        chk("mrst_stay_idle", int'(busy), 0);

        run_vec(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
